// File: rtl/avalon_timer_array.sv
// avalon_timer_array
//
// Array of independent programmable timer channels behind a simple
// word-addressed read/write bus. Each channel owns four words:
//   4c+0 counter (R/W), 4c+1 compare (R/W), 4c+2 control (R/W), 4c+3 status.
// Word 4*CHANNELS is the read-only global pending register. All other
// addresses read as zero, and writes to them are ignored.
//
// Control: [0] en, [1] dir (1 up / 0 down), [2] ire, [3] reload,
//          [4] oneshot, [15:8] prescale.
// Status:  [0] match flag (write 1 to clear), [1] live (counter < compare).
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   read       read strobe, one cycle per access
//   write      write strobe, one cycle per access
//   address    word address (AW bits)
//   dataIn     write data
//   readValid  high the cycle after an accepted read
//   dataOut    read data while readValid is high, zero otherwise
//   irq        registered OR of the global pending bits
module avalon_timer_array #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 32,
  localparam int AW       = $clog2(CHANNELS) + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] address,
  input  logic [31:0]   dataIn,
  output logic          readValid,
  output logic [31:0]   dataOut,
  output logic          irq
);

  localparam int CW = AW - 2;

  // Address decode shared by every channel: the upper address bits pick the
  // channel, the low two bits pick the word inside it.
  logic [CW-1:0]       chanIdx;
  logic                inChannels;
  logic                selGlobal;
  logic [31:0]         chanRead [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [31:0]         readData;

  logic                readValid_q;
  logic [31:0]         dataOut_q;
  logic                irq_q;

  assign chanIdx    = address[AW-1:2];
  assign inChannels = (32'(address) < 32'(4 * CHANNELS));
  assign selGlobal  = (32'(address) == 32'(4 * CHANNELS));

  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic             en_q, en_d;
    logic             dir_q, dir_d;
    logic             ire_q, ire_d;
    logic             reload_q, reload_d;
    logic             oneshot_q, oneshot_d;
    logic [7:0]       prescale_q, prescale_d;
    logic [7:0]       preCount_q, preCount_d;
    logic             flag_q, flag_d;

    logic             sel;
    logic             wrCount, wrCompare, wrControl, wrStatus;
    logic             tick, terminal, live;
    logic [WIDTH-1:0] stepped;
    logic [31:0]      ctrlWord, statusWord;

    assign sel       = inChannels && (chanIdx == CW'(c));
    assign wrCount   = write && sel && (address[1:0] == 2'd0);
    assign wrCompare = write && sel && (address[1:0] == 2'd1);
    assign wrControl = write && sel && (address[1:0] == 2'd2);
    assign wrStatus  = write && sel && (address[1:0] == 2'd3);

    // A tick fires on the cycle the prescaler reaches its programmed value,
    // giving one counter step per prescale+1 enabled cycles.
    assign tick     = en_q && (preCount_q == prescale_q);
    assign terminal = dir_q ? (count_q == compare_q) : (count_q == '0);
    assign stepped  = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    assign live     = (count_q < compare_q);

    // Next-state for one channel. Timer behaviour is resolved first and bus
    // writes are layered on top, so a bus write to counter or control
    // overrides whatever the timer did that cycle. The match flag is the
    // exception: a terminal tick sets it even if software clears it in the
    // same cycle, so an event is never lost.
    always_comb begin
      count_d    = count_q;
      compare_d  = compare_q;
      en_d       = en_q;
      dir_d      = dir_q;
      ire_d      = ire_q;
      reload_d   = reload_q;
      oneshot_d  = oneshot_q;
      prescale_d = prescale_q;
      preCount_d = preCount_q;
      flag_d     = flag_q;

      if (wrControl || !en_q || tick) begin
        preCount_d = '0;
      end else begin
        preCount_d = preCount_q + 8'd1;
      end

      if (tick) begin
        if (!terminal) begin
          count_d = stepped;
        end else if (oneshot_q) begin
          en_d = 1'b0;
        end else if (reload_q) begin
          count_d = dir_q ? '0 : compare_q;
        end else begin
          count_d = stepped;
        end
      end

      if (wrStatus && dataIn[0]) begin
        flag_d = 1'b0;
      end
      if (tick && terminal) begin
        flag_d = 1'b1;
      end

      if (wrCount) begin
        count_d = dataIn[WIDTH-1:0];
      end
      if (wrCompare) begin
        compare_d = dataIn[WIDTH-1:0];
      end
      if (wrControl) begin
        en_d       = dataIn[0];
        dir_d      = dataIn[1];
        ire_d      = dataIn[2];
        reload_d   = dataIn[3];
        oneshot_d  = dataIn[4];
        prescale_d = dataIn[15:8];
      end
    end

    // Channel state registers; compare resets to all ones so a freshly reset
    // up-counter does not match early.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q    <= '0;
        compare_q  <= '1;
        en_q       <= 1'b0;
        dir_q      <= 1'b0;
        ire_q      <= 1'b0;
        reload_q   <= 1'b0;
        oneshot_q  <= 1'b0;
        prescale_q <= '0;
        preCount_q <= '0;
        flag_q     <= 1'b0;
      end else begin
        count_q    <= count_d;
        compare_q  <= compare_d;
        en_q       <= en_d;
        dir_q      <= dir_d;
        ire_q      <= ire_d;
        reload_q   <= reload_d;
        oneshot_q  <= oneshot_d;
        prescale_q <= prescale_d;
        preCount_q <= preCount_d;
        flag_q     <= flag_d;
      end
    end

    assign ctrlWord   = {16'd0, prescale_q, 3'd0, oneshot_q, reload_q,
                         ire_q, dir_q, en_q};
    assign statusWord = {30'd0, live, flag_q};

    assign chanRead[c] = (address[1:0] == 2'd0) ? 32'(count_q)   :
                         (address[1:0] == 2'd1) ? 32'(compare_q) :
                         (address[1:0] == 2'd2) ? ctrlWord       :
                                                  statusWord;
    assign pending[c]  = flag_q & ire_q;
  end

  // Read mux over current register contents, so a read that coincides with
  // a write returns the value from before the write.
  always_comb begin
    readData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (inChannels && (chanIdx == CW'(c))) begin
        readData = chanRead[c];
      end
    end
    if (selGlobal) begin
      readData = 32'(pending);
    end
  end

  // Registered bus response and interrupt. dataOut is forced to zero
  // whenever readValid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readValid_q <= 1'b0;
      dataOut_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      readValid_q <= read;
      dataOut_q   <= read ? readData : 32'd0;
      irq_q       <= |pending;
    end
  end

  assign readValid = readValid_q;
  assign dataOut   = dataOut_q;
  assign irq       = irq_q;

endmodule
